sm_multi_seq: RTL and testbench
===============================

SM_MULTI_SEQ -- requirements
Module: sm_multi_seq

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand width in bits including the sign bit in the MSB; legal range 2..32.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 SHALL provide port: p1  input  WIDTH  sign-magnitude multiplicand; MSB is the sign, WIDTH-1 LSBs are the magnitude.
REQ-006 SHALL provide port: p2  input  WIDTH  sign-magnitude multiplier, same encoding as p1.
REQ-007 SHALL provide port: busy  output  1  high while a multiply is iterating.
REQ-008 SHALL provide port: done  output  1  single-cycle pulse marking a new valid result.
REQ-009 SHALL provide port: result  output  2*WIDTH-1  sign-magnitude product; MSB is the sign, 2*(WIDTH-1) LSBs are the magnitude.

Function
REQ-010 SHALL implement FSM states IDLE, CALC and FIN, all registered.
REQ-011 IDLE or FIN with start=1 SHALL latch p1 and p2, clear the accumulator, load the iteration counter with WIDTH-1 and go to CALC.
REQ-012 IDLE or FIN with start=0 SHALL go to or stay in IDLE.
REQ-013 CALC SHALL process one multiplier magnitude bit per cycle, LSB first, by shift-and-add into a 2*(WIDTH-1)-bit accumulator.
REQ-014 CALC SHALL decrement the counter each cycle; on the edge that completes iteration WIDTH-1 it SHALL register result and go to FIN.
REQ-015 Latency SHALL be fixed: start high in cycle 0 gives done high in cycle WIDTH; independent of operand values.
REQ-016 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in FIN.
REQ-017 start asserted while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-018 start asserted in FIN SHALL be accepted; back-to-back operations SHALL have no idle bubble.
REQ-019 The result magnitude SHALL equal magnitude(p1) * magnitude(p2) exactly, with no truncation or overflow.
REQ-020 The result sign SHALL equal sign(p1) XOR sign(p2), subject to REQ-026.
REQ-021 result SHALL hold its value from FIN until the next FIN; it SHALL not change during CALC.
REQ-022 p1 and p2 changes after the accept edge SHALL not affect the operation in progress.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, result=0, counter=0, accumulator=0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow it.
REQ-025 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-026 Macro SM_ZERO_NORM_EN, when defined: a zero product magnitude SHALL force the result sign to 0 (no negative zero). When undefined: the sign SHALL be the raw XOR of the operand signs, even for a zero magnitude.

Verification
REQ-027 WIDTH=3: p1=3'b011, p2=3'b010, start for 1 cycle -> done in cycle 3, result=5'b00110.
REQ-028 WIDTH=3: p1=3'b111, p2=3'b011 -> result=5'b11001.
REQ-029 WIDTH=3: p1=3'b101, p2=3'b000 -> result=5'b10000 without SM_ZERO_NORM_EN; 5'b00000 with it.
REQ-030 WIDTH=8: p1=8'h7F, p2=8'hFF -> result=15'h7F01, done in cycle 8.
REQ-031 WIDTH=8: second start mid-CALC with different operands -> ignored; first result delivered. Start held in FIN -> next done in exactly 8 cycles.
REQ-032 WIDTH=8: rst_n low in cycle 4 of an operation -> busy, done and result go to 0 asynchronously; no done pulse follows.

Source files
------------

// File: rtl/sm_multi_seq.sv
// sm_multi_seq: sequential sign-magnitude multiplier, one shift-and-add step per clock.
// Build option: define SM_ZERO_NORM_EN to force a positive sign on a zero product.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin a multiply (accepted in IDLE or FIN, ignored while busy)
//   p1     - sign-magnitude multiplicand, sign in MSB
//   p2     - sign-magnitude multiplier, sign in MSB
//   busy   - high while iterating (CALC)
//   done   - one-cycle pulse with a new result (FIN)
//   result - sign-magnitude product, sign in MSB, 2*(WIDTH-1) magnitude bits
module sm_multi_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   p1,
    input  logic [WIDTH-1:0]   p2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-2:0] result
);

    localparam int MW = WIDTH - 1;
    localparam int AW = 2 * MW;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [AW-1:0] mcand;
    logic [MW-1:0] mplier;
    logic          sgn;

    logic [AW-1:0] acc_nxt;
    logic          sgn_fin;

    // Partial product of the current multiplier bit added into the running sum.
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef SM_ZERO_NORM_EN
    assign sgn_fin = sgn & (|acc_nxt);
`else
    assign sgn_fin = sgn;
`endif

    assign busy = (state == CALC);
    assign done = (state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sgn    <= 1'b0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    if (start) begin
                        mcand  <= {{MW{1'b0}}, p1[MW-1:0]};
                        mplier <= p2[MW-1:0];
                        sgn    <= p1[WIDTH-1] ^ p2[WIDTH-1];
                        acc    <= '0;
                        cnt    <= CW'(MW);
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    // Last multiplier bit: publish the finished product.
                    if (cnt == CW'(1)) begin
                        result <= {sgn_fin, acc_nxt};
                        state  <= FIN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_multi_seq.sv
// tb_sm_multi_seq: directed and random checks of sm_multi_seq at WIDTH=8 and WIDTH=3.
// Expected products come from plain integer arithmetic on the operand magnitudes.
module tb_sm_multi_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [14:0] res8;

    logic        start3 = 1'b0;
    logic [2:0]  a3 = '0;
    logic [2:0]  b3 = '0;
    logic        busy3;
    logic        done3;
    logic [4:0]  res3;

    int checks = 0;
    int failures = 0;
    logic [63:0] last8 = '0;
    logic [63:0] last3 = '0;

    always #5 clk = ~clk;

    sm_multi_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .p1(a8), .p2(b8),
        .busy(busy8), .done(done8), .result(res8)
    );

    sm_multi_seq #(.WIDTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .p1(a3), .p2(b3),
        .busy(busy3), .done(done3), .result(res3)
    );

    function automatic logic [63:0] model(int w, logic [31:0] a, logic [31:0] b);
        longint unsigned mask, ma, mb, mag;
        logic s;
        mask = (64'd1 << (w - 1)) - 1;
        ma = a & mask;
        mb = b & mask;
        mag = ma * mb;
        s = a[w-1] ^ b[w-1];
`ifdef SM_ZERO_NORM_EN
        if (mag == 0) s = 1'b0;
`endif
        return (longint'(s) << (2 * (w - 1))) | mag;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 multiply from IDLE or FIN; returns in the FIN cycle.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit disturb);
        logic [63:0] e;
        e = model(8, {24'd0, a}, {24'd0, b});
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c < 8; c++) begin
            chk("busy8", {63'd0, busy8}, 64'd1);
            chk("done8_calc", {63'd0, done8}, 64'd0);
            chk("hold8", {49'd0, res8}, last8);
            if (disturb) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                start8 = (c == 3);
            end
            tick();
        end
        start8 = 1'b0;
        chk("done8", {63'd0, done8}, 64'd1);
        chk("busy8_fin", {63'd0, busy8}, 64'd0);
        chk("res8", {49'd0, res8}, e);
        last8 = e;
    endtask

    task automatic go3(input logic [2:0] a, input logic [2:0] b);
        logic [63:0] e;
        e = model(3, {29'd0, a}, {29'd0, b});
        a3 = a;
        b3 = b;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c < 3; c++) begin
            chk("busy3", {63'd0, busy3}, 64'd1);
            chk("done3_calc", {63'd0, done3}, 64'd0);
            chk("hold3", {59'd0, res3}, last3);
            tick();
        end
        chk("done3", {63'd0, done3}, 64'd1);
        chk("res3", {59'd0, res3}, e);
        last3 = e;
    endtask

    initial begin
        #2;
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_res", {49'd0, res8}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Small-width directed cases.
        go3(3'b011, 3'b010);
        chk("r027", {59'd0, res3}, 64'b00110);
        go3(3'b111, 3'b011);
        chk("r028", {59'd0, res3}, 64'b11001);
        go3(3'b101, 3'b000);
`ifdef SM_ZERO_NORM_EN
        chk("r029", {59'd0, res3}, 64'b00000);
`else
        chk("r029", {59'd0, res3}, 64'b10000);
`endif
        tick();
        chk("idle3", {63'd0, done3 | busy3}, 64'd0);
        chk("keep3", {59'd0, res3}, last3);

        // Full magnitude range and sign.
        go8(8'h7F, 8'hFF, 1'b0);
        chk("r030", {49'd0, res8}, 64'h7F01);
        tick();
        chk("idle8", {63'd0, done8 | busy8}, 64'd0);
        chk("keep8", {49'd0, res8}, last8);

        // Mid-CALC start and operand changes ignored, then back-to-back.
        go8(8'h85, 8'h13, 1'b1);
        go8(8'h2A, 8'hC7, 1'b0);
        go8(8'h80, 8'h55, 1'b0);
        tick();

        // Reset in cycle 4 of an operation.
        a8 = 8'h7F;
        b8 = 8'h7F;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy8}, 64'd0);
        chk("arst_done", {63'd0, done8}, 64'd0);
        chk("arst_res", {49'd0, res8}, 64'd0);
        last8 = '0;
        last3 = '0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("no_done", {63'd0, done8}, 64'd0);
            tick();
        end

        // Random operands, random gaps and disturbances.
        for (int i = 0; i < 25; i++) begin
            go8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk("gap8", {63'd0, done8 | busy8}, 64'd0);
            end
            go3(3'($urandom), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
